// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multi-cycle stalls,
// mispredict flushes, and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadE,
  input  logic              MulStartE,
  input  logic              MispredictE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MUL_BUSY} state_t;

  localparam logic [3:0] LOAD_INIT = 4'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [3:0] MUL_INIT  = 4'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       load_haz;

  // Memory stage wins over writeback: it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign load_haz = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (MispredictE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (MulStartE) begin
            if (MUL_LAT > 1) begin
              StallF = 1'b1;
              StallD = 1'b1;
              StallE = 1'b1;
              FlushM = 1'b1;
              if (MUL_LAT > 2) begin
                cnt_n   = MUL_INIT;
                state_n = MUL_BUSY;
              end
            end
          end else if (load_haz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_n   = LOAD_INIT;
              state_n = LOAD_STALL;
            end
          end
        end
        LOAD_STALL: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (cnt == 4'd0) state_n = IDLE;
          else             cnt_n   = cnt - 4'd1;
        end
        MUL_BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          // The launch cycle in IDLE is one of the MUL_LAT-1 stalls, so leave one early.
          if (cnt <= 4'd1) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cycles <= '0;
    else if (StallF && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a (LOAD_LAT=1, MUL_LAT=4) and
// instance b (LOAD_LAT=3, MUL_LAT=8, CNT_W=4) share the same stimulus.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, MulStartE, MispredictE;

  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy;
  logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .MUL_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MulStartE(MulStartE), .MispredictE(MispredictE),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
    .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .busy(a_busy), .stall_cycles(a_cnt)
  );

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .MUL_LAT(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MulStartE(MulStartE), .MispredictE(MispredictE),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
    .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .busy(b_busy), .stall_cycles(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, MemReadE, MulStartE, MispredictE} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Events presented under reset must not leak to outputs.
    MulStartE = 1'b1; MemReadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; MispredictE = 1'b1;
    @(negedge clk);
    chk("rst_busy",   {31'd0, a_busy}, 32'd0);
    chk("rst_stallf", {31'd0, a_sf}, 32'd0);
    chk("rst_flushd", {31'd0, a_fd}, 32'd0);
    chk("rst_cnt",    {16'd0, a_cnt}, 32'd0);
    do_reset();

    // Forwarding.
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7;
    #1 chk("fwdA_M", {30'd0, a_fa}, 32'd2);
    RegWriteM = 1'b0;
    #1 chk("fwdA_W", {30'd0, a_fa}, 32'd1);
    RegWriteM = 1'b1; Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
    #1 chk("fwdA_x0", {30'd0, a_fa}, 32'd0);
    RdM = 5'd3; RdW = 5'd7; Rs2E = 5'd7;
    #1 chk("fwdB_W", {30'd0, a_fb}, 32'd1);
    Rs2E = 5'd3;
    #1 chk("fwdB_M", {30'd0, a_fb}, 32'd2);
    do_reset();

    // Single-bubble load-use (instance a).
    MemReadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
    #1;
    chk("ld1_stallf", {31'd0, a_sf}, 32'd1);
    chk("ld1_stalld", {31'd0, a_sd}, 32'd1);
    chk("ld1_flushe", {31'd0, a_fe}, 32'd1);
    chk("ld1_stalle", {31'd0, a_se}, 32'd0);
    chk("ld1_busy",   {31'd0, a_busy}, 32'd0);
    tick();
    MemReadE = 1'b0;
    #1;
    chk("ld1_done",  {31'd0, a_sf}, 32'd0);
    chk("ld1_busy2", {31'd0, a_busy}, 32'd0);
    chk("ld1_count", {16'd0, a_cnt}, 32'd1);
    do_reset();

    // Three-bubble load-use (instance b).
    MemReadE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    #1;
    chk("ld3_c1_stall", {31'd0, b_sf}, 32'd1);
    chk("ld3_c1_busy",  {31'd0, b_busy}, 32'd0);
    tick();
    MemReadE = 1'b0;
    #1;
    chk("ld3_c2_stall", {31'd0, b_sf}, 32'd1);
    chk("ld3_c2_flush", {31'd0, b_fe}, 32'd1);
    chk("ld3_c2_busy",  {31'd0, b_busy}, 32'd1);
    tick();
    chk("ld3_c3_stall", {31'd0, b_sf}, 32'd1);
    chk("ld3_c3_busy",  {31'd0, b_busy}, 32'd1);
    tick();
    chk("ld3_c4_stall", {31'd0, b_sf}, 32'd0);
    chk("ld3_c4_busy",  {31'd0, b_busy}, 32'd0);
    chk("ld3_count",    {28'd0, b_cnt}, 32'd3);
    MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    chk("ld_rd0_a", {31'd0, a_sf}, 32'd0);
    chk("ld_rd0_b", {31'd0, b_sf}, 32'd0);
    do_reset();

    // Multi-cycle op, MUL_LAT=4 -> 3 stall cycles (instance a).
    MulStartE = 1'b1;
    #1;
    chk("mul_c1_stallf", {31'd0, a_sf}, 32'd1);
    chk("mul_c1_stalle", {31'd0, a_se}, 32'd1);
    chk("mul_c1_flushm", {31'd0, a_fm}, 32'd1);
    chk("mul_c1_busy",   {31'd0, a_busy}, 32'd0);
    tick();
    MulStartE = 1'b0; MispredictE = 1'b1;
    #1;
    chk("mul_c2_stall",  {31'd0, a_sf}, 32'd1);
    chk("mul_c2_busy",   {31'd0, a_busy}, 32'd1);
    chk("mul_c2_noflsh", {31'd0, a_fd}, 32'd0);
    tick();
    MispredictE = 1'b0;
    #1;
    chk("mul_c3_stall", {31'd0, a_sd}, 32'd1);
    tick();
    chk("mul_c4_stall", {31'd0, a_sf}, 32'd0);
    chk("mul_c4_busy",  {31'd0, a_busy}, 32'd0);
    chk("mul_count",    {16'd0, a_cnt}, 32'd3);
    do_reset();

    // Mispredict beats a simultaneous load-use hazard.
    MispredictE = 1'b1; MemReadE = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
    #1;
    chk("mp_flushd", {31'd0, a_fd}, 32'd1);
    chk("mp_flushe", {31'd0, a_fe}, 32'd1);
    chk("mp_stallf", {31'd0, a_sf}, 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("mp_idle_a", {31'd0, a_busy}, 32'd0);
    chk("mp_idle_b", {31'd0, b_busy}, 32'd0);
    chk("mp_count",  {16'd0, a_cnt}, 32'd0);
    do_reset();

    // Reset during the second cycle of a MUL_LAT=8 stall (instance b).
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    #1;
    chk("mrst_pre_busy", {31'd0, b_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_stallf", {31'd0, b_sf}, 32'd0);
    chk("mrst_flushm", {31'd0, b_fm}, 32'd0);
    chk("mrst_busy",   {31'd0, b_busy}, 32'd0);
    chk("mrst_cnt",    {28'd0, b_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mrst_after", {31'd0, b_sf}, 32'd0);
    do_reset();

    // Back-to-back multi-cycle ops keep StallF high; b saturates at 15.
    MulStartE = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_b_14", {28'd0, b_cnt}, 32'd14);
    end
    chk("sat_b_15", {28'd0, b_cnt}, 32'd15);
    chk("cnt_a_20", {16'd0, a_cnt}, 32'd20);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
